// File: rtl/alu_pipe.sv
// Parametrised accumulator ALU with valid/ready handshake and an output result register.
// MUL is a WIDTH-cycle shift-add sequence; all other opcodes finish in one cycle.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] accum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_ABS   = 4'd5;
  localparam logic [3:0] OP_CAL   = 4'd6;
  localparam logic [3:0] OP_CND   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_SADD  = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SRA   = 4'd11;

  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               zero_mul_q, zero_mul_d;

  logic [WIDTH:0]     add_ext, sub_ext;
  logic               add_ovf, sub_ovf;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   op_res;
  logic               op_carry, op_ovf;
  logic               accept;

  assign in_ready  = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

  always_comb begin
    add_ext  = {1'b0, accum} + {1'b0, data};
    sub_ext  = {1'b0, accum} - {1'b0, data};
    add_ovf  = (accum[MSB] == data[MSB]) && (add_ext[MSB] != accum[MSB]);
    sub_ovf  = (accum[MSB] != data[MSB]) && (sub_ext[MSB] != accum[MSB]);
    shamt    = data[SW-1:0];
    op_res   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    case (opcode)
      OP_PASSA: op_res = accum;
      OP_ADD: begin
        op_res   = add_ext[WIDTH-1:0];
        op_carry = add_ext[WIDTH];
        op_ovf   = add_ovf;
      end
      OP_SUB: begin
        op_res   = sub_ext[WIDTH-1:0];
        op_carry = sub_ext[WIDTH];
        op_ovf   = sub_ovf;
      end
      OP_AND:   op_res = accum & data;
      OP_XOR:   op_res = accum ^ data;
      OP_ABS:   op_res = accum[MSB] ? -accum : accum;
      OP_CAL:   op_res = (accum << 2) + accum + (accum >> 3);
      OP_CND:   op_res = accum[MSB] ? -data : ~data;
      OP_SADD: begin
        op_ovf = add_ovf;
        if (add_ovf) op_res = accum[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else         op_res = add_ext[WIDTH-1:0];
      end
      OP_SHL:   op_res = accum << shamt;
      OP_SRA:   op_res = $signed(accum) >>> shamt;
      default:  op_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    zero_mul_d  = zero_mul_q;

    // A write in the same edge overrides this consume, giving back-to-back results.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            mcand_d    = {{WIDTH{1'b0}}, accum};
            mplier_d   = data;
            prod_d     = '0;
            cnt_d      = '0;
            zero_mul_d = (accum == '0);
            state_d    = S_MULT;
          end else begin
            alu_out_d   = op_res;
            zero_d      = (accum == '0);
            carry_d     = op_carry;
            ovf_d       = op_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MULT: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      S_DONE: begin
        if (!out_valid_q || out_ready) begin
          alu_out_d   = prod_q[WIDTH-1:0];
          zero_d      = zero_mul_q;
          carry_d     = 1'b0;
          ovf_d       = |prod_q[2*WIDTH-1:WIDTH];
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      zero_mul_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      zero_mul_q  <= zero_mul_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed vector table, handshake
// corner sequences and random operations against an arithmetic reference model.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] data;
  logic [7:0] accum;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_out;
  logic       zero;
  logic       carry;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .data      (data),
    .accum     (accum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       o;
    logic       z;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       o;
    logic       z;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model from the operation rules using plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ia, ib, sa, sb, t, n;
    ia = int'(a);
    ib = int'(b);
    sa = a[7] ? ia - 256 : ia;
    sb = b[7] ? ib - 256 : ib;
    n  = ib % 8;
    e.c = 1'b0;
    e.o = 1'b0;
    e.z = (ia == 0);
    t   = 0;
    case (op)
      4'd0: t = ia;
      4'd1: begin t = ia + ib; e.c = (t > 255); e.o = (sa + sb > 127) || (sa + sb < -128); end
      4'd2: begin t = ia - ib; e.c = (ia < ib); e.o = (sa - sb > 127) || (sa - sb < -128); end
      4'd3: t = ia & ib;
      4'd4: t = ia ^ ib;
      4'd5: t = (sa < 0) ? -sa : sa;
      4'd6: t = ((ia * 4) % 256) + ia + ia / 8;
      4'd7: t = (sa < 0) ? 256 - ib : 255 - ib;
      4'd8: begin t = ia * ib; e.o = (t > 255); end
      4'd9: begin
        t = sa + sb;
        if (t > 127)       begin t = 127;  e.o = 1'b1; end
        else if (t < -128) begin t = -128; e.o = 1'b1; end
      end
      4'd10: t = ia * (1 << n);
      4'd11: t = (sa >= 0) ? sa / (1 << n) : -((-sa + (1 << n) - 1) / (1 << n));
      default: t = 0;
    endcase
    e.res = 8'(t & 255);
    return e;
  endfunction

  // Offer one op, wait for acceptance and for its result (out_ready assumed 1).
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output exp_t got);
    int n;
    opcode   = op;
    accum    = a;
    data     = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
    got.res = alu_out;
    got.c   = carry;
    got.o   = ovf;
    got.z   = zero;
  endtask

  vec_t vecs[17];
  logic [3:0] xop;

  initial begin
    exp_t got, e;
    int   k;
    logic seen;

    xop = 4'b00x0;
    vecs[0]  = '{4'd1,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'd2,  8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'd1,  8'h00, 8'h12, 8'h12, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{4'd6,  8'h37, 8'h00, 8'h19, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'd5,  8'hC9, 8'h00, 8'h37, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd7,  8'h80, 8'h05, 8'hFB, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'hF,  8'h55, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{xop,   8'h00, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{4'd9,  8'h70, 8'h20, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4'd9,  8'h90, 8'h90, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'd11, 8'h84, 8'h02, 8'hE1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd10, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'd4,  8'h3C, 8'h0F, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'd0,  8'hA5, 8'h11, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'd2,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{4'd1,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};

    // Reset held two cycles with a valid ADD offered.
    reset = 1'b1; in_valid = 1'b1; opcode = 4'd1; accum = 8'h12; data = 8'h34; out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_out", 32'(alu_out), 32'd0);
    chk("rst_flags", {29'd0, zero, carry, ovf}, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, got);
      chk($sformatf("vec%0d_res", i), 32'(got.res), 32'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), {29'd0, got.z, got.c, got.o},
          {29'd0, vecs[i].z, vecs[i].c, vecs[i].o});
    end

    // MUL latency and in_ready low throughout.
    opcode = 4'd8; accum = 8'h13; data = 8'h0E; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      chk("mul_in_ready_low", 32'(in_ready), 32'd0);
      tick(); k++;
      seen = out_valid;
    end
    chk("mul_latency", 32'(k), 32'd9);
    chk("mul_res", 32'(alu_out), 32'h0A);
    chk("mul_flags", {29'd0, zero, carry, ovf}, 32'd1);

    // Reset in the middle of a multiply discards it.
    opcode = 4'd8; accum = 8'hFF; data = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("midrst_alu_out", 32'(alu_out), 32'd0);
    chk("midrst_flags", {29'd0, zero, carry, ovf}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    chk("midrst_idle", 32'(in_ready), 32'd1);

    // Backpressure: held result, second op stalls, then no-bubble handover.
    out_ready = 1'b0;
    opcode = 4'd4; accum = 8'h3C; data = 8'h0F; in_valid = 1'b1;
    tick();
    opcode = 4'd1; accum = 8'h01; data = 8'h02;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_held", 32'(alu_out), 32'h33);
      chk("bp_stall", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_up", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_nobubble_valid", 32'(out_valid), 32'd1);
    chk("bp_nobubble_res", 32'(alu_out), 32'h03);
    tick();
    chk("bp_consumed", 32'(out_valid), 32'd0);

    // MUL result waits in DONE under backpressure, then is delivered.
    out_ready = 1'b0;
    opcode = 4'd8; accum = 8'h0B; data = 8'h07; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("mul_bp_valid", 32'(out_valid), 32'd1);
    chk("mul_bp_res", 32'(alu_out), 32'h4D);
    chk("mul_bp_stall", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("mul_bp_consumed", 32'(out_valid), 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (i % 8 == 0) a = 8'h00;
      e = model(op, a, b);
      run_op(op, a, b, got);
      chk($sformatf("rnd%0d_op%0d_res", i, op), 32'(got.res), 32'(e.res));
      chk($sformatf("rnd%0d_op%0d_flags", i, op), {29'd0, got.z, got.c, got.o},
          {29'd0, e.z, e.c, e.o});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 8-bit accumulator ALU. It supports any operand width and a 4-bit opcode that keeps the eight legacy operations and adds multiply, saturating add and shifts. Results and flags are held in an output register with valid/ready flow control. Multiply is iterative (multi-cycle), so upstream sequencers stall on `in_ready`.

## Interface
- `WIDTH`, default 8: operand/result width; legal range ≥ 4.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operands and opcode valid.
- `in_ready` out 1: block can accept; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `opcode` in 4: operation select.
- `data` in WIDTH: operand B.
- `accum` in WIDTH: operand A.
- `out_valid` out 1: result register holds an unconsumed result.
- `out_ready` in 1: downstream consumes the result when `out_valid && out_ready`.
- `alu_out` out WIDTH: result.
- `zero` out 1: `accum == 0`, sampled at accept (legacy semantics).
- `carry` out 1: carry/borrow flag.
- `ovf` out 1: overflow/saturation flag.

## Operation
- Opcodes, all results truncated to WIDTH:
  - 0 PASSA: `accum`.
  - 1 ADD: `accum + data`.
  - 2 SUB: `accum - data`.
  - 3 AND: `accum & data`.
  - 4 XOR: `accum ^ data`.
  - 5 ABS: `accum[MSB] ? -accum : accum`.
  - 6 CAL: `(accum<<2) + accum + (accum>>3)`, each term WIDTH bits.
  - 7 CND: `accum[MSB] ? -data : ~data`.
  - 8 MUL: low WIDTH bits of unsigned `accum*data`.
  - 9 SADD: signed saturating add.
  - 10 SHL: `accum << data[clog2(WIDTH)-1:0]`.
  - 11 SRA: arithmetic shift right by the same amount.
  - 12–15, or any X/Z opcode bit: result 0, `carry`=`ovf`=0.
- Flags:
  - `carry`: ADD unsigned carry-out; SUB borrow (`accum < data` unsigned); 0 for all other opcodes.
  - `ovf`: ADD/SUB signed overflow; SADD set when the result saturated; MUL set when the high half of the product is nonzero; 0 otherwise.
- FSM states:
  - IDLE: accepts any op. A single-cycle op writes result and flags and sets `out_valid`. MUL latches operands and clears the partial product, then goes to MULT.
  - MULT: one shift-add iteration per cycle for WIDTH cycles, counter 0..WIDTH-1. After the last iteration go to DONE.
  - DONE: write the product and flags when `!out_valid || out_ready`, set `out_valid`, go to IDLE; otherwise stay in DONE.
- `in_ready = !reset && state==IDLE && (!out_valid || out_ready)`.
- `out_valid` clears on consume unless a new result is written in the same edge, in which case it stays 1.
- While `out_valid && !out_ready`: `alu_out`, `zero`, `carry` and `ovf` are held stable.

## Timing
- Reset (any state, including mid-MULT):
  - Next edge: state=IDLE, `out_valid`=0, `alu_out`=0, `zero`=0, `carry`=0, `ovf`=0, iteration counter=0.
  - `in_ready`=0 while `reset`=1.
  - Any partial multiply is discarded.
- Single-cycle ops: result visible the cycle after accept. Throughput is 1 per cycle when `out_ready`=1.
- MUL: accept at edge N, iterations on edges N+1..N+WIDTH, result written at edge N+WIDTH+1 (if not stalled). `out_valid` is high in cycle N+WIDTH+1. `in_ready`=0 from after edge N until the result is written.
- Simultaneous consume and accept at the same edge: the new result replaces the old one with no bubble.
- `in_valid` with `in_ready`=0: no effect; upstream must hold its inputs.

## Test plan
- Reset: hold `reset` 2 cycles with `in_valid`=1, opcode ADD → `in_ready`=0, `out_valid`=0, all outputs 0. Release reset → `in_ready`=1 in the next cycle.
- Arithmetic, WIDTH=8:
  - ADD 0xF0+0x20 → 0x10, `carry`=1, `ovf`=0, `zero`=0.
  - SUB 0x05−0x07 → 0xFE, `carry`=1.
  - ADD `accum`=0x00, `data`=0x12 → 0x12, `zero`=1.
- Legacy ops:
  - CAL `accum`=0x37 → 0x19.
  - ABS 0xC9 → 0x37.
  - CND `accum`=0x80, `data`=0x05 → 0xFB.
  - Opcode 4'hF or 4'b00x0 → 0.
- MUL:
  - 0x13×0x0E → `alu_out`=0x0A, `ovf`=1, `out_valid` first high 9 cycles after accept, `in_ready`=0 throughout.
  - Assert `reset` at iteration 4 → IDLE, `out_valid` never rises.
- Backpressure:
  - `out_ready`=0, XOR 0x3C^0x0F offered, then a second op → result 0x33 held, second op stalls (`in_ready`=0).
  - Raise `out_ready` → second op accepted at the consume edge, no bubble.
- SADD/shift:
  - SADD 0x70+0x20 → 0x7F, `ovf`=1.
  - SADD 0x90+0x90 → 0x80, `ovf`=1.
  - SRA 0x84 by 2 → 0xE1.
  - SHL 0x81 by 9 (amount uses 3 LSBs = 1) → 0x02.
